// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared fetch-stage types and constants
package pipeline_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INST            = 32'h0000_0000;
  localparam int unsigned PC_STEP             = 4;
  localparam logic [31:0] HALT_OPCODE_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/imem_ram.sv
// rtl/imem_ram.sv - instruction word array, synchronous write, combinational read
module imem_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // program words land here as the debug unit streams them in; contents survive reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - IF stage with load/run/halt controller; FETCH_STATS_EN adds fetch/stall counters
module fetch_unit
  import pipeline_pkg::*;
#(
  parameter int INST_SZ                   = 32,
  parameter int PC_SZ                     = 32,
  parameter int IMEM_DEPTH                = 256,
  parameter logic [INST_SZ-1:0] HALT_OPCODE = INST_SZ'(HALT_OPCODE_DEFAULT)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_load_valid,
  input  logic [INST_SZ-1:0] i_load_data,
  output logic               o_load_ready,
  output logic               o_load_full,
  input  logic               i_start,
  input  logic               i_clear,
  input  logic [PC_SZ-1:0]   i_branch_addr_D,
  input  logic [PC_SZ-1:0]   i_jump_addr_D,
  input  logic [PC_SZ-1:0]   i_rs_addr_D,
  input  logic               i_pc_src_D,
  input  logic               i_jump_D,
  input  logic               i_jump_sel_D,
  input  logic               i_stall_HD,
  input  logic               i_flush_D,
  output logic [PC_SZ-1:0]   o_pc_F,
  output logic [PC_SZ-1:0]   o_npc_F,
  output logic [PC_SZ-1:0]   o_branch_delay_slot_F,
  output logic [INST_SZ-1:0] o_instruction_F,
  output logic               o_valid_F,
  output logic               o_halted
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]        o_fetch_count,
  output logic [31:0]        o_stall_count
`endif
);

  localparam int AW = $clog2(IMEM_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  state_t             state;
  logic [PC_SZ-1:0]   pc;
  logic [PC_SZ-1:0]   pc_plus4;
  logic [PC_SZ-1:0]   pc_plus8;
  logic [PC_SZ-1:0]   pc_nxt;
  logic [AW:0]        ptr;
  logic [INST_SZ-1:0] fetch_word;
  logic               in_load;
  logic               in_run;
  logic               load_fire;
  logic               halt_hit;

  assign in_load      = (state == ST_LOAD);
  assign in_run       = (state == ST_RUN);
  // ptr counts one past the last word, so its top bit is set exactly when memory is full
  assign o_load_full  = ptr[AW];
  assign o_load_ready = in_load && !o_load_full;
  assign load_fire    = i_load_valid && o_load_ready;
  assign pc_plus4     = pc + PC_SZ'(PC_STEP);
  assign pc_plus8     = pc_plus4 + PC_SZ'(PC_STEP);
  // a stalled halt word is re-examined once the stall releases
  assign halt_hit     = in_run && !i_stall_HD && (fetch_word == HALT_OPCODE);
  assign o_pc_F       = pc;
  assign o_halted     = (state == ST_HALT);

  imem_ram #(
    .WIDTH (INST_SZ),
    .DEPTH (IMEM_DEPTH)
  ) u_imem (
    .clk   (i_clk),
    .we    (load_fire),
    .waddr (ptr[AW-1:0]),
    .wdata (i_load_data),
    .raddr (pc[AW+1:2]),
    .rdata (fetch_word)
  );

  // next PC: register jump > jump > branch > sequential; redirects override a stall, halt freezes PC
  always_comb begin
    pc_nxt = pc;
    if (in_run && !halt_hit) begin
      if (i_jump_sel_D)      pc_nxt = i_rs_addr_D;
      else if (i_jump_D)     pc_nxt = i_jump_addr_D;
      else if (i_pc_src_D)   pc_nxt = i_branch_addr_D;
      else if (!i_stall_HD)  pc_nxt = pc_plus4;
    end
  end

  // load/run/halt controller together with the PC and load pointer it owns
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state <= ST_LOAD;
      pc    <= '0;
      ptr   <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (load_fire) ptr <= ptr + PTR_ONE;
          if (i_start) begin
            state <= ST_RUN;
            pc    <= '0;
          end
        end
        ST_RUN: begin
          pc <= pc_nxt;
          if (halt_hit) state <= ST_HALT;
        end
        ST_HALT: begin
          if (i_clear) begin
            state <= ST_LOAD;
            pc    <= '0;
            ptr   <= '0;
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

  // IF/ID register: flush or idle controller inserts a NOP, stall holds, otherwise capture
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_instruction_F       <= INST_SZ'(NOP_INST);
      o_valid_F             <= 1'b0;
      o_npc_F               <= '0;
      o_branch_delay_slot_F <= '0;
    end else if (!in_run || i_flush_D) begin
      o_instruction_F <= INST_SZ'(NOP_INST);
      o_valid_F       <= 1'b0;
    end else if (!i_stall_HD) begin
      o_instruction_F       <= fetch_word;
      o_valid_F             <= 1'b1;
      o_npc_F               <= pc_plus4;
      o_branch_delay_slot_F <= pc_plus8;
    end
  end

`ifdef FETCH_STATS_EN
  logic fetch_capture;
  assign fetch_capture = in_run && !i_flush_D && !i_stall_HD;

  // saturating statistics, restarted with every new program run
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_fetch_count <= '0;
      o_stall_count <= '0;
    end else if (in_load && i_start) begin
      o_fetch_count <= '0;
      o_stall_count <= '0;
    end else begin
      if (fetch_capture && !(&o_fetch_count))         o_fetch_count <= o_fetch_count + 32'd1;
      if (in_run && i_stall_HD && !(&o_stall_count))  o_stall_count <= o_stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised successor instruction-fetch stage for the MIPS pipeline: PC register, next-PC selection, word-addressed instruction memory of configurable depth, and a registered IF/ID output with valid/flush.
- Adds a load/run/halt controller so the debug unit streams a program in over a valid/ready handshake before execution starts.
- Sits between the debug unit (program load) and the ID stage (branch/jump targets, hazard-detection stall).

Parameters:
- INST_SZ, 32, instruction width in bits
- PC_SZ, 32, program counter width in bits
- IMEM_DEPTH, 256, instruction memory depth in words (power of two, >= 4)
- HALT_OPCODE, 32'hFFFF_FFFF, instruction word that stops fetching

Ports:
- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_load_valid  in  1  debug unit presents a program word
- i_load_data  in  INST_SZ  program word to store
- o_load_ready  out  1  word accepted this cycle when high with i_load_valid
- o_load_full  out  1  memory full, further words dropped
- i_start  in  1  leave LOAD, begin execution at PC 0
- i_clear  in  1  from HALT, return to LOAD
- i_branch_addr_D  in  PC_SZ  branch target
- i_jump_addr_D  in  PC_SZ  jump target
- i_rs_addr_D  in  PC_SZ  GPR[rs] target (JR/JALR)
- i_pc_src_D  in  1  take branch
- i_jump_D  in  1  take jump
- i_jump_sel_D  in  1  take register jump
- i_stall_HD  in  1  hold PC and IF/ID (active high)
- i_flush_D  in  1  squash IF/ID contents
- o_pc_F  out  PC_SZ  current PC
- o_npc_F  out  PC_SZ  registered PC+4 of instruction in IF/ID
- o_branch_delay_slot_F  out  PC_SZ  registered PC+8 of instruction in IF/ID
- o_instruction_F  out  INST_SZ  registered instruction (0 = NOP when invalid)
- o_valid_F  out  1  IF/ID holds a real instruction
- o_halted  out  1  controller in HALT

Behaviour:
- Reset (i_reset low, asynchronous): state LOAD, PC=0, load pointer=0, o_instruction_F=0, o_npc_F=0, o_branch_delay_slot_F=0, o_valid_F=0, o_halted=0, o_load_full=0; memory contents not cleared.
- States: LOAD -> RUN on i_start; RUN -> HALT when the word at PC equals HALT_OPCODE; HALT -> LOAD on i_clear. Other inputs ignored in each state.
- LOAD: o_load_ready = !o_load_full. On valid&&ready, write mem[ptr], ptr++. When ptr reaches IMEM_DEPTH, o_load_full=1. i_start and a write in the same cycle: the write is performed, then RUN begins with PC=0.
- RUN, next PC priority: i_jump_sel_D > i_jump_D > i_pc_src_D > PC+4, all modulo 2^PC_SZ. Redirects apply even when i_stall_HD is high (the branch resolves in ID). Otherwise a stall holds PC.
- Memory read is combinational at word index PC[log2(IMEM_DEPTH)+1:2]. Bits [1:0] are ignored. The index wraps modulo IMEM_DEPTH.
- IF/ID register, priority flush > stall > load:
  - i_flush_D: instruction=0, valid=0.
  - i_stall_HD: hold.
  - Otherwise capture the instruction, PC+4 and PC+8, valid=1.
- Latency: the instruction at PC appears on o_instruction_F one cycle after PC is presented.
- HALT detect: the halt word is captured into IF/ID with valid=1. PC freezes at the halt address. The IF/ID register then loads NOP (valid=0) every cycle. o_halted=1.
- A halt word encountered while i_stall_HD is high is not acted on until the stall releases.
- Outside RUN: PC holds and the IF/ID register outputs NOP/valid=0.
- Leaving HALT via i_clear resets PC=0 and ptr=0 and clears o_load_full.

Optional Feature:
- FETCH_STATS_EN defined:
  - Adds output o_fetch_count (32 bits): counts cycles in which IF/ID captured a valid instruction.
  - Adds output o_stall_count (32 bits): counts RUN cycles with i_stall_HD high.
  - Both counters clear on reset and on i_start, and saturate at all-ones.
- FETCH_STATS_EN undefined: the ports and counters are absent.

Decomposition:
- Shared package `pipeline_pkg`:
  - state enum (ST_LOAD, ST_RUN, ST_HALT)
  - constants NOP_INST = 0, PC_STEP = 4
  - HALT_OPCODE default
- One sub-module `imem_ram`: parametrised word array with synchronous write and combinational read. The controller, PC logic and IF/ID register stay in fetch_unit.

Test Plan:
- Load 3 words {0x20010005, 0x20020007, 0xFFFFFFFF}, then i_start -> o_instruction_F sequence 0x20010005, 0x20020007, 0xFFFFFFFF with o_npc_F 4, 8, 12. o_halted=1 afterwards, PC stays at 8.
- IMEM_DEPTH=4, stream 6 words -> o_load_full=1 after the 4th. Words 5 and 6 are not written and o_load_ready=0 for them.
- RUN with i_pc_src_D=1, i_jump_D=1, i_jump_sel_D=1 and targets 0x40, 0x80, 0xC0 in the same cycle -> next PC=0xC0. With only the branch asserted, next PC=0x40.
- i_stall_HD high for 2 cycles at PC=8 -> PC and o_instruction_F held for 2 cycles, then fetch resumes at 12.
- i_flush_D and i_stall_HD high together -> o_valid_F=0, o_instruction_F=0 next cycle.
- Drive i_reset low asynchronously mid-RUN at PC=0x10 -> PC=0, state LOAD, o_valid_F=0 immediately, without waiting for a clock edge.
